assoc_way_bank: RTL

- Parametrised N-way set-associative tag/data store; successor to the single-way dirty/valid/tag/data array bundle.
- Holds all ways of one cache level and does, internally:
  - hit detection;
  - pseudo-LRU victim selection;
  - write-hit dirty marking;
  - a multi-cycle flush sequencer.
- Sits between the cache control FSM and the memory-side datapath. Control FSM issues lookup/write/fill/flush; datapath consumes hit data and victim line.

---
 rtl/assoc_way_bank.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/assoc_way_bank.sv
// assoc_way_bank: N-way set-associative tag/data store. It provides hit detection,
// pseudo-LRU victim selection (lowest invalid way first), write-hit dirty marking
// and a multi-cycle flush sequencer.
// Optional macro WAY_BANK_STATS_EN adds saturating hit/miss counters and a
// stats_clr input.
module assoc_way_bank #(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 8,
  parameter int unsigned TAG_W  = 9,
  parameter int unsigned LINE_W = 128,
  localparam int unsigned IDX_W = $clog2(SETS),
  localparam int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  index,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [LINE_W-1:0] line_in,
  input  logic              write_hit,
  input  logic              fill,
  input  logic              flush_req,
  output logic              hit,
  output logic [WAY_W-1:0]  hit_way,
  output logic [LINE_W-1:0] data_out,
  output logic [WAY_W-1:0]  victim_way,
  output logic              victim_valid,
  output logic              victim_dirty,
  output logic [TAG_W-1:0]  victim_tag,
`ifdef WAY_BANK_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count,
`endif
  output logic              flush_busy,
  output logic              flush_done
);

  // 1 bit per set for 2 ways; 3-bit tree {right leaf, left leaf, root} for 4 ways
  localparam int unsigned PLRU_W = (WAYS == 4) ? 3 : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [LINE_W-1:0] data_mem [SETS][WAYS];
  logic [WAYS-1:0]   valid    [SETS];
  logic [WAYS-1:0]   dirty    [SETS];
  logic [PLRU_W-1:0] plru     [SETS];

  state_t           state;
  logic [IDX_W-1:0] cnt;

  logic             hit_raw;
  logic [WAY_W-1:0] hit_idx;
  logic             inv_any;
  logic [WAY_W-1:0] inv_idx;
  logic [WAY_W-1:0] vic_idx;
  logic             acc_fill;
  logic             acc_wr;
  logic [WAY_W-1:0] tgt_way;

  // Way chosen for replacement by the PLRU bits (bits name the victim side)
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] p);
    logic [2:0] pp;
    logic [1:0] v;
    pp = 3'(p);
    if (WAYS == 2) v = {1'b0, pp[0]};
    else           v = pp[0] ? {1'b1, pp[2]} : {1'b0, pp[1]};
    return WAY_W'(v);
  endfunction

  // New PLRU bits pointing away from the way just touched
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] p,
                                                   input logic [WAY_W-1:0]  w);
    logic [2:0] pp;
    logic [1:0] ww;
    pp = 3'(p);
    ww = 2'(w);
    if (WAYS == 2) begin
      pp[0] = ~ww[0];
    end else begin
      pp[0] = ~ww[1];
      if (!ww[1]) pp[1] = ~ww[0];
      else        pp[2] = ~ww[0];
    end
    return PLRU_W'(pp);
  endfunction

  // Lookup: lowest matching valid way, lowest invalid way, and victim choice
  always_comb begin
    hit_raw = 1'b0;
    hit_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid[index][w] && (tag_mem[index][w] == tag_in)) begin
        hit_raw = 1'b1;
        hit_idx = WAY_W'(w);
      end
      if (!valid[index][w]) begin
        inv_any = 1'b1;
        inv_idx = WAY_W'(w);
      end
    end
    vic_idx = inv_any ? inv_idx : plru_victim(plru[index]);
  end

  assign hit          = hit_raw & ~flush_busy;
  assign hit_way      = hit_idx;
  assign victim_way   = vic_idx;
  assign victim_valid = valid[index][vic_idx];
  assign victim_dirty = dirty[index][vic_idx];
  assign victim_tag   = tag_mem[index][vic_idx];
  assign data_out     = data_mem[index][hit ? hit_idx : vic_idx];

  // Only an idle bank accepts writes; flush beats fill, fill beats write_hit
  assign acc_fill = (state == IDLE) & ~flush_req & fill;
  assign acc_wr   = (state == IDLE) & ~flush_req & ~fill & write_hit & hit_raw;
  assign tgt_way  = acc_fill ? vic_idx : hit_idx;

  // Tag/data storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (acc_fill) begin
      tag_mem[index][vic_idx]  <= tag_in;
      data_mem[index][vic_idx] <= line_in;
    end else if (acc_wr) begin
      data_mem[index][hit_idx] <= line_in;
    end
  end

  // Flush sequencer plus valid/dirty/PLRU state maintenance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        plru[s]  <= '0;
      end
      state      <= IDLE;
      cnt        <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_req) begin
            state      <= SCAN;
            cnt        <= '0;
            flush_busy <= 1'b1;
          end else if (acc_fill || acc_wr) begin
            valid[index][tgt_way] <= 1'b1;
            dirty[index][tgt_way] <= acc_wr;
            plru[index]           <= plru_touch(plru[index], tgt_way);
          end
        end
        SCAN: begin
          valid[cnt] <= '0;
          dirty[cnt] <= '0;
          plru[cnt]  <= '0;
          cnt        <= cnt + IDX_W'(1);
          if (cnt == IDX_W'(SETS - 1)) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          flush_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          flush_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef WAY_BANK_STATS_EN
  // Saturating statistics: accepted write hits and accepted fills
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (stats_clr) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (acc_wr && (hit_count != 16'hFFFF))    hit_count  <= hit_count + 16'd1;
      if (acc_fill && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule
